// File: rtl/tl45_pkg.sv
// Shared tl45 core types and constants used by the register file slice.
package tl45_pkg;

    localparam int unsigned TL45_DATA_W = 32;

    typedef logic [3:0]  tl45_reg_t;
    typedef logic [31:0] tl45_word_t;

    localparam tl45_reg_t TL45_ZERO_REG = '0;

endpackage

// File: rtl/tl45_rf_bypass.sv
// Per-read-port selection: stored value, overridden by the highest-index
// enabled write to the same address; register 0 and reset force zero.
module tl45_rf_bypass
    import tl45_pkg::*;
#(
    parameter int unsigned DATA_W = TL45_DATA_W,
    parameter int unsigned AW     = 4,
    parameter int unsigned NWR    = 2
) (
    input  logic                       reset,
    input  logic [AW-1:0]              rd_addr,
    input  logic [DATA_W-1:0]          stored_data,
    input  logic                       stored_busy,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR-1:0][AW-1:0]     wr_addr,
    input  logic [NWR-1:0][DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_busy
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(TL45_ZERO_REG);

    always_comb begin
        rd_data = stored_data;
        rd_busy = stored_busy;
        // Ascending scan so the highest matching write port is applied last.
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j] == rd_addr)) begin
                rd_data = wr_data[j];
                rd_busy = 1'b0;
            end
        end
        if (reset || (rd_addr == ZERO_ADDR)) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/tl45_regfile_mp.sv
// Multi-port tl45 register file: storage, write priority, busy scoreboard
// with a registered busy counter, and per-port write-to-read bypass.
module tl45_regfile_mp
    import tl45_pkg::*;
#(
    parameter int unsigned DATA_W = TL45_DATA_W,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NRD-1:0][AW-1:0]     rd_addr,
    output logic [NRD-1:0][DATA_W-1:0] rd_data,
    output logic [NRD-1:0]             rd_busy,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR-1:0][AW-1:0]     wr_addr,
    input  logic [NWR-1:0][DATA_W-1:0] wr_data,
    input  logic                       claim_en,
    input  logic [AW-1:0]              claim_addr,
    output logic [AW:0]                busy_cnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(TL45_ZERO_REG);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [NREGS-1:0]  clr_vec;
    logic [NREGS-1:0]  set_vec;
    logic [AW:0]       busy_cnt_nxt;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j] != ZERO_ADDR)) clr_vec[wr_addr[j]] = 1'b1;
        end
        if (claim_en && (claim_addr != ZERO_ADDR)) set_vec[claim_addr] = 1'b1;
        // Claim dominates a same-cycle writeback to the same register.
        busy_nxt = (busy & ~clr_vec) | set_vec;
    end

    // Incremental count: each register contributes at most one step per edge.
    always_comb begin
        busy_cnt_nxt = busy_cnt;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (set_vec[r] && !busy[r])
                busy_cnt_nxt = busy_cnt_nxt + CNT_ONE;
            else if (clr_vec[r] && busy[r] && !set_vec[r])
                busy_cnt_nxt = busy_cnt_nxt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) mem[r] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            // Later ports overwrite earlier ones targeting the same entry.
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j] != ZERO_ADDR)) mem[wr_addr[j]] <= wr_data[j];
            end
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        tl45_rf_bypass #(
            .DATA_W (DATA_W),
            .AW     (AW),
            .NWR    (NWR)
        ) u_bypass (
            .reset       (reset),
            .rd_addr     (rd_addr[i]),
            .stored_data (mem[rd_addr[i]]),
            .stored_busy (busy[rd_addr[i]]),
            .wr_en       (wr_en),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .rd_data     (rd_data[i]),
            .rd_busy     (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_tl45_regfile_mp.sv
// Directed scoreboard bench for tl45_regfile_mp: stimulus queues expected
// values per cycle, a negedge monitor pops and compares them.
module tb_tl45_regfile_mp;

    localparam int unsigned NRD   = 3;
    localparam int unsigned NWR   = 2;
    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_CNT  = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NRD-1:0][AW-1:0] rd_addr;
    logic [NRD-1:0][DW-1:0] rd_data;
    logic [NRD-1:0]         rd_busy;
    logic [NWR-1:0]         wr_en;
    logic [NWR-1:0][AW-1:0] wr_addr;
    logic [NWR-1:0][DW-1:0] wr_data;
    logic                   claim_en;
    logic [AW-1:0]          claim_addr;
    logic [AW:0]            busy_cnt;

    always #5 clk = ~clk;

    tl45_regfile_mp #(
        .DATA_W (DW),
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_cnt   (busy_cnt)
    );

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    exp_t        me;
    logic [31:0] act;
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk) cyc++;

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            me = sbq.pop_front();
            case (me.kind)
                K_DATA:  act = rd_data[me.port];
                K_BUSY:  act = {31'b0, rd_busy[me.port]};
                default: act = 32'(busy_cnt);
            endcase
            total++;
            if (act !== me.val) begin
                bad++;
                $display("FAIL %s port%0d: got %h want %h", me.name, me.port, act, me.val);
            end
        end
    end

    task automatic push(input int kind, input int port, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.port = port; e.val = v; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic exp_rd(input int port, input logic [31:0] d, input logic b, input string nm);
        push(K_DATA, port, d, {nm, "_data"});
        push(K_BUSY, port, {31'b0, b}, {nm, "_busy"});
    endtask

    task automatic exp_cnt(input int c, input string nm);
        push(K_CNT, 0, 32'(c), nm);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wr_en[p]   = 1'b1;
        wr_addr[p] = AW'(a);
        wr_data[p] = d;
    endtask

    task automatic claim(input int a);
        claim_en   = 1'b1;
        claim_addr = AW'(a);
    endtask

    initial begin
        reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0; rd_addr = '0;

        // Reset cycle: write attempt is not bypassed while reset is high.
        next_cycle(); reset = 1'b1;
        wr(0, 4, 32'h5555_AAAA); claim(6);
        rd_addr[0] = 4; rd_addr[1] = 6; rd_addr[2] = 1;
        exp_rd(0, 32'h0, 1'b0, "rst_bypass_off");
        exp_rd(1, 32'h0, 1'b0, "rst_r6");
        exp_cnt(0, "rst_cnt");

        // Sweep all registers after reset.
        for (int r = 0; r < NREGS; r += NRD) begin
            next_cycle();
            for (int p = 0; p < NRD; p++) begin
                rd_addr[p] = AW'((r + p) % NREGS);
                exp_rd(p, 32'h0, 1'b0, "post_rst_sweep");
            end
            exp_cnt(0, "post_rst_cnt");
        end

        // Same-cycle bypass then stored value.
        next_cycle(); wr(0, 3, 32'hDEAD_BEEF); rd_addr[1] = 3; rd_addr[0] = 0;
        exp_rd(1, 32'hDEAD_BEEF, 1'b0, "r3_bypass");
        next_cycle(); rd_addr[1] = 3;
        exp_rd(1, 32'hDEAD_BEEF, 1'b0, "r3_stored");

        // Write-port priority on r5.
        next_cycle(); wr(0, 5, 32'h11); wr(1, 5, 32'h22); rd_addr[0] = 5;
        exp_rd(0, 32'h22, 1'b0, "r5_prio_bypass");
        next_cycle(); wr(0, 0, 32'hFFFF_FFFF); rd_addr[0] = 0; rd_addr[1] = 5;
        exp_rd(0, 32'h0, 1'b0, "r0_write_bypass");
        exp_rd(1, 32'h22, 1'b0, "r5_prio_stored");
        next_cycle(); rd_addr[0] = 0; wr(0, 6, 32'hAA); wr(1, 9, 32'hBB);
        exp_rd(0, 32'h0, 1'b0, "r0_stored");
        next_cycle(); rd_addr[0] = 6; rd_addr[1] = 9; rd_addr[2] = 3;
        exp_rd(0, 32'hAA, 1'b0, "r6_port0");
        exp_rd(1, 32'hBB, 1'b0, "r9_port1");
        exp_rd(2, 32'hDEAD_BEEF, 1'b0, "r3_port2");

        // Claim / writeback interaction on r7.
        next_cycle(); claim(7); rd_addr[0] = 7;
        exp_rd(0, 32'h0, 1'b0, "r7_claim_same_cycle");
        exp_cnt(0, "cnt_before_claim");
        next_cycle(); rd_addr[0] = 7;
        exp_rd(0, 32'h0, 1'b1, "r7_busy");
        exp_cnt(1, "cnt_r7");
        next_cycle(); wr(0, 7, 32'h77); claim(7); rd_addr[0] = 7;
        exp_rd(0, 32'h77, 1'b0, "r7_wr_claim_bypass");
        exp_cnt(1, "cnt_wr_claim");
        next_cycle(); rd_addr[0] = 7;
        exp_rd(0, 32'h77, 1'b1, "r7_claim_wins");
        exp_cnt(1, "cnt_claim_wins");
        next_cycle(); wr(1, 7, 32'h78); rd_addr[0] = 7;
        exp_rd(0, 32'h78, 1'b0, "r7_wb_bypass");
        exp_cnt(1, "cnt_before_clear");
        next_cycle(); rd_addr[0] = 7; claim(0);
        exp_rd(0, 32'h78, 1'b0, "r7_cleared");
        exp_cnt(0, "cnt_cleared");
        next_cycle(); rd_addr[0] = 0; claim(8);
        exp_rd(0, 32'h0, 1'b0, "r0_never_busy");
        exp_cnt(0, "cnt_claim_r0");

        // Double claim counts once; dual writeback clears two at once.
        next_cycle(); claim(8);
        exp_cnt(1, "cnt_r8");
        next_cycle(); claim(9);
        exp_cnt(1, "cnt_r8_double");
        next_cycle(); claim(10);
        exp_cnt(2, "cnt_r9");
        next_cycle(); wr(0, 9, 32'h99); wr(1, 10, 32'h1010);
        rd_addr[0] = 8; rd_addr[1] = 9; rd_addr[2] = 10;
        exp_rd(0, 32'h0, 1'b1, "r8_busy");
        exp_rd(1, 32'h99, 1'b0, "r9_wb_bypass");
        exp_cnt(3, "cnt_three");
        next_cycle(); wr(0, 8, 32'h88); rd_addr[1] = 9; rd_addr[2] = 10;
        exp_rd(1, 32'h99, 1'b0, "r9_cleared");
        exp_rd(2, 32'h1010, 1'b0, "r10_cleared");
        exp_cnt(1, "cnt_dual_clear");
        next_cycle();
        exp_cnt(0, "cnt_all_clear");

        // Claims then reset with a pending write to r2.
        next_cycle(); claim(1);
        next_cycle(); claim(2);
        exp_cnt(1, "cnt_c1");
        next_cycle(); claim(3);
        exp_cnt(2, "cnt_c2");
        next_cycle(); reset = 1'b1; wr(0, 2, 32'h1234); claim(4); rd_addr[0] = 2;
        exp_rd(0, 32'h0, 1'b0, "r2_during_reset");
        exp_cnt(3, "cnt_c3");
        next_cycle(); rd_addr[0] = 1; rd_addr[1] = 2; rd_addr[2] = 3;
        exp_rd(0, 32'h0, 1'b0, "r1_after_reset");
        exp_rd(1, 32'h0, 1'b0, "r2_not_written");
        exp_rd(2, 32'h0, 1'b0, "r3_cleared");
        exp_cnt(0, "cnt_after_reset");
        next_cycle(); rd_addr[0] = 4; rd_addr[1] = 5;
        exp_rd(0, 32'h0, 1'b0, "r4_claim_dropped");
        exp_rd(1, 32'h0, 1'b0, "r5_cleared");
        exp_cnt(0, "cnt_claim_dropped");

        next_cycle();
        next_cycle();
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tl45_regfile_mp.md
# tl45_regfile_mp

Parametrised multi-port register file for the tl45 core. It is the successor to the single-write, dual-read register file and sits between decode (reads and destination claim) and writeback (writes). Beyond storage it adds write-to-read bypass, a per-register busy scoreboard, write-port priority and a synchronous clear. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits.
- `NREGS`, 16, number of registers; power of two, ≥ 2. `AW = $clog2(NREGS)`.
- `NRD`, 2, number of read ports, ≥ 1.
- `NWR`, 2, number of write ports, ≥ 1; a higher index has higher priority.

Ports:
- `clk`, in, 1, the single clock.
- `reset`, in, 1, synchronous, active-high.
- `rd_addr`, in, `NRD`×`AW`, read addresses.
- `rd_data`, out, `NRD`×`DATA_W`, read data, combinational.
- `rd_busy`, out, `NRD`, scoreboard bit of the addressed register, combinational.
- `wr_en`, in, `NWR`, write enables.
- `wr_addr`, in, `NWR`×`AW`, write addresses.
- `wr_data`, in, `NWR`×`DATA_W`, write data.
- `claim_en`, in, 1, mark `claim_addr` busy (instruction issued with this destination).
- `claim_addr`, in, `AW`, destination being claimed.
- `busy_cnt`, out, `AW+1`, registered count of busy registers.

## Operation
- Storage is `NREGS`×`DATA_W` flops plus `NREGS` busy bits. Entry 0 is never written: its data reads 0 and its busy bit reads 0.
- Write: on each edge, for every `j` with `wr_en[j]` and `wr_addr[j]≠0`, store `wr_data[j]`. If several ports target the same address, the highest `j` wins.
- Writeback clears busy: any enabled write to address `a≠0` clears `busy[a]`.
- Claim: if `claim_en` and `claim_addr≠0`, set `busy[claim_addr]`. If a claim and a writeback hit the same register in the same cycle, the claim wins and the bit ends at 1.
- Read port `i`:
  - If `rd_addr[i]=0`: `rd_data=0`, `rd_busy=0`.
  - Else, if any enabled write matches `rd_addr[i]`: `rd_data` is the `wr_data` of the highest matching `j` (bypass), and `rd_busy=0`.
  - Otherwise: `rd_data` and `rd_busy` are the stored values.
  - Claims never affect same-cycle reads.
- `busy_cnt` equals the popcount of the busy bits after the edge. It is updated incrementally (+1 per claim of a non-busy register, −1 per clear of a busy register, net 0 when both apply) and must always equal the popcount.
- Reset: at an edge with `reset=1`, all data becomes 0, all busy bits 0 and `busy_cnt` 0. Writes and claims in that cycle are discarded. While `reset=1`, bypass is disabled and `rd_data`/`rd_busy` read 0 on all ports. Asserting reset mid-operation drops all pending state with no partial update.

## Timing
- Read latency is 0 cycles (combinational from `rd_addr`, `wr_*` and `reset`).
- A write is stored at edge N; from then on the array holds it. It is visible in cycle N through bypass.
- A claim at edge N makes `rd_busy=1` from cycle N+1.
- `busy_cnt` is registered and updates at the same edge as the bits it counts.
- Reset values: all outputs read 0 during reset and in the first cycle after it, except reads bypassed from a write in that cycle.

## Structure
- Shared package `tl45_pkg`: `DATA_W` default, `tl45_reg_t` (`logic [3:0]`), `tl45_word_t` (`logic [31:0]`) and `TL45_ZERO_REG = 0`.
- One sub-module, `tl45_rf_bypass`: per-read-port priority mux over the `NWR` write ports plus the stored value. It is instantiated `NRD` times via generate.
- The top level holds the arrays, write-priority logic, scoreboard and counter.

## Test plan
- Reset, then read all registers → every `rd_data=0`, `rd_busy=0`, `busy_cnt=0`.
- Port0 writes r3=0xDEADBEEF while port1 reads r3 in the same cycle → `rd_data=0xDEADBEEF` that cycle and the following cycle.
- Both write ports target r5 (0x11 on port0, 0x22 on port1) → r5 reads 0x22. Writing 0xFFFF_FFFF to r0 → r0 still reads 0.
- Claim r7 → next cycle `rd_busy=1`, `busy_cnt=1`. Write r7 plus claim r7 in the same cycle → busy stays 1, `busy_cnt=1`. Write r7 alone → `rd_busy=0`, `busy_cnt=0`.
- Claim r1, r2, r3 in consecutive cycles, then assert reset together with a write to r2 → after reset, all data 0, `busy_cnt=0`, and r2 is not written.
- Random stress with `NRD=3`, `NWR=2`, `NREGS=32` against a reference model → the read data, busy bits and `busy_cnt`/popcount invariant all hold every cycle.
